// File: rtl/fixed_point_divider_pkg.sv
// Shared types and constants for the fixed-point divider.
// State encodings, FPU opcode slot and latency helper.
package fixed_point_divider_pkg;

   // Divider sequencer states; FIX is only entered when signed mode is built
   typedef enum logic [1:0] {
      FXD_DIV_IDLE = 2'd0,
      FXD_DIV_RUN  = 2'd1,
      FXD_DIV_DONE = 2'd2,
      FXD_DIV_FIX  = 2'd3
   } fxd_div_state_t;

   localparam int unsigned FXD_DIV_STATE_W = 2;

   // Opcode reserved for the FPU result mux
   localparam logic [3:0] FPU_DIV = 4'b0100;

   // Edges from start acceptance to the ready pulse
   function automatic int unsigned fxd_div_latency(
      input int unsigned width,
      input int unsigned fbits,
      input bit          signed_en
   );
      return width + fbits + (signed_en ? 1 : 0);
   endfunction

endpackage

// File: rtl/fixed_point_div_step.sv
// One restoring-division step: shift, trial subtract, restore.
// Pure combinational; the caller owns all state.
module fixed_point_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem,
   input  logic             shift_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic             q_bit
);

   logic [WIDTH+1:0] wide;
   logic [WIDTH:0]   trial;

   // Shift in the next dividend bit and keep the difference if it fits
   always_comb begin
      wide     = {rem, shift_in};
      q_bit    = (wide >= {2'b00, divisor});
      trial    = wide[WIDTH:0] - {1'b0, divisor};
      rem_next = q_bit ? trial : wide[WIDTH:0];
   end

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential radix-2 restoring divider, Q(WIDTH-FBITS).FBITS.
// Define FIXED_DIV_SIGNED_EN for two's-complement operands.
module fixed_point_divider
   import fixed_point_divider_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int FBITS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] operand_1,
   input  logic [WIDTH-1:0] operand_2,
   output logic [WIDTH-1:0] result,
   output logic             ready,
   output logic             busy,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int N     = WIDTH + FBITS;
   localparam int CNT_W = $clog2(N);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0] SAT_U    = '1;

   fxd_div_state_t   state;
   logic [CNT_W-1:0] cnt;
   logic [N-1:0]     dvd;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] divisor;

   logic [WIDTH:0]   rem_next;
   logic             q_bit;
   logic [N-1:0]     q_next;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] dz_value;
   logic [WIDTH-1:0] fin_result;
   logic             fin_ovf;

`ifdef FIXED_DIV_SIGNED_EN

   localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [N-1:0]     MAG_LIM =
      {{(N-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

   logic [N-1:0] q;
   logic         neg;

   // Magnitudes in, signed saturation and negation out
   always_comb begin
      q_next   = {q[N-2:0], q_bit};
      a_mag    = operand_1[WIDTH-1] ? -operand_1 : operand_1;
      b_mag    = operand_2[WIDTH-1] ? -operand_2 : operand_2;
      dz_value = SAT_POS;
      fin_ovf  = neg ? (q > MAG_LIM) : (q >= MAG_LIM);
      if (fin_ovf) begin
         fin_result = neg ? SAT_NEG : SAT_POS;
      end else begin
         fin_result = neg ? -q[WIDTH-1:0] : q[WIDTH-1:0];
      end
   end

`else

   // Top quotient bit is never stored; it only feeds the overflow test
   logic [N-2:0] q;

   // Unsigned width rule on the quotient including the final bit
   always_comb begin
      q_next     = {q, q_bit};
      a_mag      = operand_1;
      b_mag      = operand_2;
      dz_value   = SAT_U;
      fin_ovf    = |q_next[N-1:WIDTH];
      fin_result = fin_ovf ? SAT_U : q_next[WIDTH-1:0];
   end

`endif

   fixed_point_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem      (rem),
      .shift_in (dvd[N-1]),
      .divisor  (divisor),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   // Sequencer: accept, iterate one quotient bit per edge, publish
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= FXD_DIV_IDLE;
         cnt         <= '0;
         dvd         <= '0;
         rem         <= '0;
         divisor     <= '0;
         q           <= '0;
`ifdef FIXED_DIV_SIGNED_EN
         neg         <= 1'b0;
`endif
         result      <= '0;
         ready       <= 1'b0;
         busy        <= 1'b0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         unique case (state)
            FXD_DIV_IDLE: begin
               ready <= 1'b0;
               if (start) begin
                  busy <= 1'b1;
                  if (operand_2 == '0) begin
                     result      <= dz_value;
                     div_by_zero <= 1'b1;
                     overflow    <= 1'b0;
                     ready       <= 1'b1;
                     state       <= FXD_DIV_DONE;
                  end else begin
                     dvd     <= {a_mag, {FBITS{1'b0}}};
                     rem     <= '0;
                     divisor <= b_mag;
                     q       <= '0;
                     cnt     <= CNT_LAST;
`ifdef FIXED_DIV_SIGNED_EN
                     neg     <= operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
`endif
                     state   <= FXD_DIV_RUN;
                  end
               end
            end
            FXD_DIV_RUN: begin
               rem <= rem_next;
               dvd <= {dvd[N-2:0], 1'b0};
`ifdef FIXED_DIV_SIGNED_EN
               q   <= q_next;
`else
               q   <= q_next[N-2:0];
`endif
               cnt <= cnt - CNT_ONE;
               if (cnt == '0) begin
`ifdef FIXED_DIV_SIGNED_EN
                  state       <= FXD_DIV_FIX;
`else
                  result      <= fin_result;
                  overflow    <= fin_ovf;
                  div_by_zero <= 1'b0;
                  ready       <= 1'b1;
                  state       <= FXD_DIV_DONE;
`endif
               end
            end
`ifdef FIXED_DIV_SIGNED_EN
            FXD_DIV_FIX: begin
               result      <= fin_result;
               overflow    <= fin_ovf;
               div_by_zero <= 1'b0;
               ready       <= 1'b1;
               state       <= FXD_DIV_DONE;
            end
`endif
            FXD_DIV_DONE: begin
               ready <= 1'b0;
               busy  <= 1'b0;
               state <= FXD_DIV_IDLE;
            end
            default: begin
               ready <= 1'b0;
               busy  <= 1'b0;
               state <= FXD_DIV_IDLE;
            end
         endcase
      end
   end

endmodule
